player_link_decoder: RTL

PLAYER_LINK_DECODER -- requirements
Module: player_link_decoder

---
 rtl/player_link_decoder_pkg.sv | 11 +
 rtl/player_link_decoder_uart_rx_core.sv | 76 +++++++
 rtl/player_link_decoder.sv | 62 ++++++
 3 files changed

// File: rtl/player_link_decoder_pkg.sv
// player_link_decoder_pkg: command byte field positions, lane defaults and UART receiver state encoding
package player_link_decoder_pkg;
  localparam int BIT_GAME_RESET = 7;
  localparam int BIT_RESERVED = 6;
  localparam int BIT_FIRING = 5;
  localparam int BIT_PROJ_TYPE = 4;
  localparam int LANE_MSB = 3;
  localparam int NUM_LANES_DEF = 9;
  localparam int CENTER_LANE_DEF = 5;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
endpackage

// File: rtl/player_link_decoder_uart_rx_core.sv
// uart_rx_core: 8N1 LSB-first receiver; clk, rst (async active-low), rx -> data byte, 1-cycle valid, 1-cycle stop_err
module uart_rx_core import player_link_decoder_pkg::*; #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       stop_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID = CW'(CLKS_PER_BIT / 2 - 1);
  rx_state_e state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0] idx, idx_d;
  logic [7:0] sh_d;
  logic s1, rxs, valid_d, err_d;
  always_comb begin
    state_d = state;
    cnt_d = cnt + 1'b1;
    idx_d = idx;
    sh_d = data;
    valid_d = 1'b0;
    err_d = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        state_d = rxs ? IDLE : START;
      end
      START: if (cnt == MID) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_d = '0;
        sh_d = {rxs, data[7:1]};
        idx_d = idx + 3'd1;
        state_d = idx == 3'd7 ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_d = '0;
        valid_d = rxs;
        err_d = !rxs;
        state_d = rxs ? IDLE : BREAK;
      end
      BREAK: begin
        cnt_d = '0;
        state_d = rxs ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      data <= '0;
      valid <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      s1 <= rx;
      rxs <= s1;
      state <= state_d;
      cnt <= cnt_d;
      idx <= idx_d;
      data <= sh_d;
      valid <= valid_d;
      stop_err <= err_d;
    end
endmodule

// File: rtl/player_link_decoder.sv
// player_link_decoder: UART player command decoder; clk, rst (async active-low), rx -> lane/proj_type/firing state, fire_pulse/game_reset/byte_valid/frame_err pulses, err_count
module player_link_decoder import player_link_decoder_pkg::*; #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int CENTER_LANE = CENTER_LANE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [3:0] lane,
  output logic       proj_type,
  output logic       firing,
  output logic       fire_pulse,
  output logic       game_reset,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] err_count
);
  localparam logic [3:0] NL = 4'(NUM_LANES);
  localparam logic [3:0] CL = 4'(CENTER_LANE);
  logic [7:0] rx_byte;
  logic [3:0] code, new_lane;
  logic rx_valid, stop_err, is_gr, reject, accept, err, new_fire, new_pt;
  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .data(rx_byte),
    .valid(rx_valid),
    .stop_err(stop_err)
  );
  always_comb begin
    code = rx_byte[LANE_MSB:0];
    is_gr = rx_byte[BIT_GAME_RESET];
    reject = rx_valid && (rx_byte[BIT_RESERVED] || (!is_gr && code > NL));
    accept = rx_valid && !reject;
    err = stop_err || reject;
    new_lane = (is_gr || code == 4'd0) ? CL : code;
    new_fire = !is_gr && rx_byte[BIT_FIRING];
    new_pt = !is_gr && rx_byte[BIT_PROJ_TYPE];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lane <= CL;
      firing <= 1'b0;
      proj_type <= 1'b0;
      fire_pulse <= 1'b0;
      game_reset <= 1'b0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      lane <= accept ? new_lane : lane;
      firing <= accept ? new_fire : firing;
      proj_type <= accept ? new_pt : proj_type;
      fire_pulse <= accept && !firing && new_fire;
      game_reset <= accept && is_gr;
      byte_valid <= accept;
      frame_err <= err;
      err_count <= (err && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
endmodule
